// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 16-bit asynchronous SRAM bus. The SRAM
// controller and the sram_chip_model responder both import this package.
//   SRAM_DQ_W   - data bus width
//   SRAM_ADDR_W - word address width
//   rd_stage_t  - one read-pipeline stage (valid bit plus data word)
//   sram_log2   - index width needed to address a power-of-two depth
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int SRAM_DQ_W   = 16;
  localparam int SRAM_ADDR_W = 18;

  typedef struct packed {
    logic                 valid;
    logic [SRAM_DQ_W-1:0] data;
  } rd_stage_t;

  // Smallest w >= 1 with 2**w >= value; used as the array index width.
  function automatic int sram_log2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage : sram_pkg

// File: rtl/sram_read_pipe.sv
// ---------------------------------------------------------------------------
// sram_read_pipe
// LAT-stage shift register carrying read data plus a valid bit. With LAT=0
// it is a pure wire so the responder behaves like an asynchronous SRAM.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (clears valid bits)
//   launch_i in   1 = this cycle is a read; 0 = bubble
//   data_i   in   read data looked up this cycle
//   stage_o  out  last stage (valid + data)
// ---------------------------------------------------------------------------
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_i,
  input  logic [SRAM_DQ_W-1:0] data_i,
  output rd_stage_t            stage_o
);

  if (LAT == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = &{1'b0, clk, rst};
    assign stage_o = '{valid: launch_i, data: data_i};
  end else begin : g_pipe
    rd_stage_t pipe_q [LAT];

    // Only the valid bits are reset; data words are don't-care until their
    // valid bit is set, so they carry no reset.
    // NOTE: non-blocking assignments keep every stage reading the value its
    // predecessor held before this edge, which is what makes it a shift.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe_q[i].valid <= 1'b0;
      end else begin
        pipe_q[0] <= '{valid: launch_i, data: data_i};
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign stage_o = pipe_q[LAT-1];
  end

endmodule : sram_read_pipe

// File: rtl/sram_chip_model.sv
// ---------------------------------------------------------------------------
// sram_chip_model
// Synthesizable stand-in for an external 16-bit asynchronous SRAM. Decodes
// SRAM_ADDR / SRAM_WE_N, captures write data from SRAM_DQ, drives read data
// back onto SRAM_DQ and keeps access statistics.
// Optional feature macro: SRAM_ERR_INJECT_EN adds err_inject, a one-shot
// that flips bit 0 of the next read word presented on the bus.
// Ports:
//   clk          in     system clock
//   rst          in     synchronous active-high reset
//   SRAM_ADDR    in     word address from the controller
//   SRAM_WE_N    in     active-low write enable
//   SRAM_DQ      inout  bidirectional 16-bit data bus
//   err_inject   in     (SRAM_ERR_INJECT_EN only) arm bit-0 corruption
//   wr_count     out    accepted writes since reset, saturating
//   rd_count     out    read cycles serviced since reset, saturating
//   last_wr_addr out    address of the most recent accepted write
//   oob_flag     out    sticky: some access used an address >= DEPTH
// ---------------------------------------------------------------------------
module sram_chip_model
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DEPTH    = 4096,
  parameter int READ_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    SRAM_ADDR,
  input  logic                 SRAM_WE_N,
  inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
`ifdef SRAM_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  output logic [CNT_W-1:0]     wr_count,
  output logic [CNT_W-1:0]     rd_count,
  output logic [ADDR_W-1:0]    last_wr_addr,
  output logic                 oob_flag
);

  localparam int IDX_W = sram_log2(DEPTH);
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  // Range check on the full address first; only then index with low bits.
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             wr_en;
  logic             rd_cycle;

  assign in_range = ({1'b0, SRAM_ADDR} < DEPTH_EXT);
  assign idx      = SRAM_ADDR[IDX_W-1:0];
  assign wr_en    = !rst && !SRAM_WE_N && in_range;
  assign rd_cycle = !rst && SRAM_WE_N;

  // ---------------- storage ----------------
  logic [SRAM_DQ_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset on purpose; contents survive rst like a
  // real chip, and a reset loop over DEPTH words would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= SRAM_DQ;
  end

  logic [SRAM_DQ_W-1:0] rd_word;
  assign rd_word = in_range ? mem[idx] : '0;

  // ---------------- read pipeline ----------------
  rd_stage_t stage;

  sram_read_pipe #(.LAT(READ_LAT)) u_read_pipe (
    .clk      (clk),
    .rst      (rst),
    .launch_i (rd_cycle),
    .data_i   (rd_word),
    .stage_o  (stage)
  );

  logic                 drive_en;
  logic [SRAM_DQ_W-1:0] dq_out;

  // Never drive while the controller writes (WE_N=0) or during reset.
  assign drive_en = rd_cycle && stage.valid;

`ifdef SRAM_ERR_INJECT_EN
  logic armed_q, armed_d;

  always_comb begin
    armed_d = armed_q;
    if (drive_en) armed_d = 1'b0;      // a presented read consumes it
    if (err_inject) armed_d = 1'b1;    // a fresh request wins
  end

  always_ff @(posedge clk) begin
    if (rst) armed_q <= 1'b0;
    else     armed_q <= armed_d;
  end

  assign dq_out = stage.data ^ {{(SRAM_DQ_W-1){1'b0}}, armed_q};
`else
  assign dq_out = stage.data;
`endif

  assign SRAM_DQ = drive_en ? dq_out : {SRAM_DQ_W{1'bz}};

  // ---------------- statistics ----------------
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d;
  logic [ADDR_W-1:0] last_wr_addr_q, last_wr_addr_d;
  logic              oob_q, oob_d;
  logic [ADDR_W-1:0] prev_addr_q;
  logic              prev_rd_q;     // previous cycle was a read cycle
  logic              rd_new;

  // A read cycle counts when it starts a new access: the address moved, or
  // the previous cycle was not a read (write, or first cycle after reset).
  assign rd_new = rd_cycle && (!prev_rd_q || (SRAM_ADDR != prev_addr_q));

  always_comb begin
    wr_count_d     = wr_count_q;
    rd_count_d     = rd_count_q;
    last_wr_addr_d = last_wr_addr_q;
    oob_d          = oob_q;
    if (wr_en) begin
      if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
      last_wr_addr_d = SRAM_ADDR;
    end
    if (rd_new && (rd_count_q != '1)) rd_count_d = rd_count_q + CNT_W'(1);
    if (!in_range) oob_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q     <= '0;
      rd_count_q     <= '0;
      last_wr_addr_q <= '0;
      oob_q          <= 1'b0;
      prev_addr_q    <= '0;
      prev_rd_q      <= 1'b0;
    end else begin
      wr_count_q     <= wr_count_d;
      rd_count_q     <= rd_count_d;
      last_wr_addr_q <= last_wr_addr_d;
      oob_q          <= oob_d;
      prev_addr_q    <= SRAM_ADDR;
      prev_rd_q      <= SRAM_WE_N;
    end
  end

  assign wr_count     = wr_count_q;
  assign rd_count     = rd_count_q;
  assign last_wr_addr = last_wr_addr_q;
  assign oob_flag     = oob_q;

endmodule : sram_chip_model

// File: doc/sram_chip_model.md
Name: sram_chip_model

Overview:
Synthesizable responder for the 16-bit asynchronous SRAM bus that the SRAM controller drives. It lets the controller and the processor datapath run in simulation, or on FPGA without the external chip. It decodes SRAM_ADDR and SRAM_WE_N, captures write data from SRAM_DQ and drives read data back onto SRAM_DQ. It also keeps write/read statistics and an out-of-range flag for test benches.

Parameters:
ADDR_W, 18, width of SRAM_ADDR.
DEPTH, 4096, number of implemented 16-bit words; must be a power of two and ≤ 2^ADDR_W.
READ_LAT, 0, read latency in clocks; 0 = asynchronous read (required for the existing controller), 1..4 = registered pipeline.
CNT_W, 16, width of statistics counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
SRAM_ADDR  in  ADDR_W  word address from controller
SRAM_WE_N  in  1  active-low write enable
SRAM_DQ  inout  16  bidirectional data bus
wr_count  out  CNT_W  writes accepted since reset, saturating
rd_count  out  CNT_W  read cycles serviced since reset, saturating
last_wr_addr  out  ADDR_W  address of most recent accepted write
oob_flag  out  1  sticky: an access hit an address ≥ DEPTH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: wr_count=0, rd_count=0, last_wr_addr=0, oob_flag=0, read pipeline valid bits=0.
- Memory array contents are not cleared by rst.
- While rst=1, SRAM_DQ is high-Z and no write occurs.
- Write: at a posedge with SRAM_WE_N=0, rst=0 and SRAM_ADDR<DEPTH:
  - mem[SRAM_ADDR] <= SRAM_DQ.
  - wr_count increments, saturating at all-ones.
  - last_wr_addr <= SRAM_ADDR.
  - The model never drives SRAM_DQ while SRAM_WE_N=0.
- Read, READ_LAT=0:
  - SRAM_DQ = mem[SRAM_ADDR] combinationally whenever SRAM_WE_N=1 and rst=0.
  - A controller that sets the address at edge k samples valid data at edge k+1.
- Read, READ_LAT=N≥1:
  - Each posedge with SRAM_WE_N=1 launches a read of SRAM_ADDR into an N-stage shift pipeline (data plus valid bit).
  - SRAM_DQ is driven from the last stage when its valid bit=1 and SRAM_WE_N=1; otherwise high-Z.
  - A write cycle inserts a bubble (valid=0).
- rd_count: increments at each posedge with SRAM_WE_N=1, rst=0, and SRAM_ADDR different from the previous cycle's SRAM_ADDR, or the previous cycle was a write. It saturates.
- Out of range (SRAM_ADDR ≥ DEPTH):
  - A write is ignored (no counter or last_wr_addr update).
  - A read returns 16'h0000.
  - oob_flag is set at that posedge and cleared only by rst.
- Address decode uses the low log2(DEPTH) bits for array indexing, after the range check on the full ADDR_W bits.
- Read-after-write to the same address on consecutive cycles returns the new data. The array is write-first; pipelined reads launched in the write cycle are bubbles, so there is no hazard.
- X or Z on SRAM_DQ during a write is stored as-is in simulation; no checking.

Optional Feature:
SRAM_ERR_INJECT_EN:
- When defined, adds an input err_inject (1 bit).
- A 1 on err_inject at a posedge arms a one-shot. The next read data presented on SRAM_DQ has bit 0 inverted, then the one-shot disarms.
- An armed state persists across write cycles until a read consumes it.
- rst disarms.
- When undefined, the port and the logic are absent; read data is never altered.

Decomposition:
- Shared package sram_pkg holds:
  - SRAM_DQ_W=16.
  - SRAM_ADDR_W=18.
  - Log2 helper function for DEPTH index width.
  - Typedef for the read-pipeline stage struct {valid, data[15:0]}.
  - These constants are also used by the SRAM controller.
- One natural sub-module, sram_read_pipe: the N-stage data/valid shift register, bypassed when READ_LAT=0.
- Array, decode, counters and bus driver stay in the top level.

Test Plan:
1. Write/read, READ_LAT=0: WE_N=0 with ADDR=18'h00010, DQ=16'hBEEF for one clock, then WE_N=1 with ADDR=18'h00010 -> SRAM_DQ=16'hBEEF in the same cycle; wr_count=1; last_wr_addr=18'h00010.
2. Controller pairing: drive the SRAM controller with mem_write, data=32'h1234_5678, address=18'h00020, then mem_read of the same address -> data_out=32'h1234_5678; wr_count=2.
3. Out of range: write 16'hAAAA to 18'h01000 with DEPTH=4096 -> oob_flag=1, wr_count unchanged; read of 18'h01000 returns 16'h0000; oob_flag stays 1 until rst.
4. READ_LAT=2: mem[5]=16'h0F0F; WE_N=1, ADDR=5 at edge k -> SRAM_DQ=16'h0F0F after edge k+2; high-Z after edge k+1.
5. Reset mid-operation: rst=1 during a WE_N=0 cycle with ADDR=7, DQ=16'h5555 -> mem[7] keeps its old value; counters=0; SRAM_DQ high-Z while rst=1.
6. With SRAM_ERR_INJECT_EN: pulse err_inject, then read mem[3]=16'h8000 -> SRAM_DQ=16'h8001 once; next read of 3 -> 16'h8000.
